// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port (I, read-only) and a load/store port (D, read/write).
// One transaction is in flight at a time; simultaneous requests alternate
// round-robin against the last granted port.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req/i_addr                fetch request and address
//   i_gnt/i_rvalid/i_rdata      fetch accept, data valid pulse, data
//   d_req/d_we/d_be/d_addr/d_wdata  data request, write enable, byte enables,
//                               address, write data
//   d_gnt/d_rvalid/d_rdata      data accept, read-data / write-done pulse, data
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory command
//   mem_rdata                   memory read data, MEM_LATENCY cycles after mem_en
//   busy                        a transaction is in flight
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    busy
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    // A zero-latency memory cannot be tracked by the countdown.
    generate
        if (MEM_LATENCY < 1) begin : g_bad_latency
            $fatal(1, "mem_port_arbiter: MEM_LATENCY must be >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_owner_d;   // 1: D port owns the transaction in flight
    logic             r_last_d;    // 1: D port won the last grant
    logic             r_we;        // transaction in flight is a write
    logic [CNT_W-1:0] r_cnt;

    logic w_pick_i;
    logic w_pick_d;
    logic w_idle;
    logic w_done;

    // Round-robin pick: on a tie the port that did not win last time goes.
    assign w_pick_i = i_req && (!d_req || r_last_d);
    assign w_pick_d = d_req && (!i_req || !r_last_d);

    // Outputs are forced low while reset is held, independent of the inputs.
    assign w_idle = (r_state == ST_IDLE) && !rst;
    assign w_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1)) && !rst;

    // State, ownership and latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b1;
            r_we      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_i || w_pick_d) begin
                        r_owner_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_we      <= w_pick_d && d_we;
                        r_cnt     <= CNT_W'(MEM_LATENCY);
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grant, memory command and response steering.
    always_comb begin
        i_gnt     = w_idle && w_pick_i;
        d_gnt     = w_idle && w_pick_d;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        busy      = (r_state == ST_WAIT) && !rst;

        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_en    = 1'b1;
            mem_be    = {BE_W{1'b1}};
            mem_addr  = i_addr;
        end

        if (w_done) begin
            if (r_owner_d) begin
                d_rvalid = 1'b1;
                // A write completion carries no data.
                d_rdata  = r_we ? '0 : mem_rdata;
            end else begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 (a_*)
// and one at MEM_LATENCY=3 (b_*), sharing clock and reset.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A, MEM_LATENCY = 1
    logic          a_i_req, a_i_gnt, a_i_rvalid;
    logic [AW-1:0] a_i_addr;
    logic [DW-1:0] a_i_rdata;
    logic          a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [BW-1:0] a_d_be;
    logic [AW-1:0] a_d_addr;
    logic [DW-1:0] a_d_wdata, a_d_rdata;
    logic          a_mem_en, a_mem_we, a_busy;
    logic [BW-1:0] a_mem_be;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata;

    // Instance B, MEM_LATENCY = 3
    logic          b_i_req, b_i_gnt, b_i_rvalid;
    logic [AW-1:0] b_i_addr;
    logic [DW-1:0] b_i_rdata;
    logic          b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [BW-1:0] b_d_be;
    logic [AW-1:0] b_d_addr;
    logic [DW-1:0] b_d_wdata, b_d_rdata;
    logic          b_mem_en, b_mem_we, b_busy;
    logic [BW-1:0] b_mem_be;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt),
        .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr),
        .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid),
        .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt),
        .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid),
        .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_i_req = 1'b1; a_i_addr = '0; a_d_req = 1'b1; a_d_we = 1'b0;
        a_d_be = '0; a_d_addr = '0; a_d_wdata = '0; a_mem_rdata = '0;
        b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_be = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;

        // Reset: outputs low even with requests asserted
        #2;
        chk("rst_i_gnt", a_i_gnt, 0);
        chk("rst_d_gnt", a_d_gnt, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_busy", a_busy, 0);
        a_i_req = 1'b0; a_d_req = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // A: single fetch, latency 1
        a_i_req = 1'b1; a_i_addr = 32'h100;
        #1;
        chk("f_i_gnt", a_i_gnt, 1);
        chk("f_d_gnt", a_d_gnt, 0);
        chk("f_mem_en", a_mem_en, 1);
        chk("f_mem_we", a_mem_we, 0);
        chk("f_mem_be", a_mem_be, 4'hF);
        chk("f_mem_addr", a_mem_addr, 32'h100);
        chk("f_busy0", a_busy, 0);
        cyc();
        a_i_req = 1'b0; a_mem_rdata = 32'hDEADBEEF;
        #1;
        chk("f_busy1", a_busy, 1);
        chk("f_i_rvalid", a_i_rvalid, 1);
        chk("f_i_rdata", a_i_rdata, 32'hDEADBEEF);
        chk("f_mem_en_wait", a_mem_en, 0);
        chk("f_d_rvalid", a_d_rvalid, 0);
        cyc();
        #1;
        chk("f_busy2", a_busy, 0);
        chk("f_i_rvalid2", a_i_rvalid, 0);

        // A: data write, latency 1
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011;
        a_d_addr = 32'h200; a_d_wdata = 32'h12345678;
        #1;
        chk("w_d_gnt", a_d_gnt, 1);
        chk("w_i_gnt", a_i_gnt, 0);
        chk("w_mem_we", a_mem_we, 1);
        chk("w_mem_be", a_mem_be, 4'b0011);
        chk("w_mem_addr", a_mem_addr, 32'h200);
        chk("w_mem_wdata", a_mem_wdata, 32'h12345678);
        cyc();
        a_d_req = 1'b0; a_mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("w_d_rvalid", a_d_rvalid, 1);
        chk("w_d_rdata", a_d_rdata, 0);
        chk("w_i_rvalid", a_i_rvalid, 0);
        chk("w_i_rdata", a_i_rdata, 0);
        cyc();

        // A: both request continuously after reset -> I, D, I, D
        rst = 1'b1; #1; rst = 1'b0;
        a_d_we = 1'b0; a_mem_rdata = 32'h0000_5A5A;
        a_i_req = 1'b1; a_d_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_i_gnt", a_i_gnt, (k % 4) == 0);
            chk("rr_d_gnt", a_d_gnt, (k % 4) == 2);
            chk("rr_both", a_i_gnt & a_d_gnt, 0);
            chk("rr_i_rvalid", a_i_rvalid, (k % 4) == 1);
            chk("rr_d_rvalid", a_d_rvalid, (k % 4) == 3);
            cyc();
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        cyc();

        // A: held fetch with address changed after grant
        a_i_req = 1'b1; a_i_addr = 32'hA0;
        #1;
        chk("h_gnt1", a_i_gnt, 1);
        chk("h_addr1", a_mem_addr, 32'hA0);
        cyc();
        a_i_addr = 32'hB0;
        #1;
        chk("h_gnt_wait", a_i_gnt, 0);
        chk("h_rvalid", a_i_rvalid, 1);
        chk("h_addr_wait", a_mem_addr, 0);
        cyc();
        #1;
        chk("h_gnt2", a_i_gnt, 1);
        chk("h_addr2", a_mem_addr, 32'hB0);
        a_i_req = 1'b0;
        cyc(); cyc();

        // B: latency 3 read, fetch raised one cycle later
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h300;
        #1;
        chk("l3_d_gnt", b_d_gnt, 1);
        cyc();                                   // T+1
        b_d_req = 1'b0; b_i_req = 1'b1; b_i_addr = 32'h400;
        #1;
        chk("l3_t1_i_gnt", b_i_gnt, 0);
        chk("l3_t1_busy", b_busy, 1);
        chk("l3_t1_rvalid", b_d_rvalid, 0);
        cyc();                                   // T+2
        #1;
        chk("l3_t2_rvalid", b_d_rvalid, 0);
        chk("l3_t2_i_gnt", b_i_gnt, 0);
        cyc();                                   // T+3
        b_mem_rdata = 32'hCAFEF00D;
        #1;
        chk("l3_t3_rvalid", b_d_rvalid, 1);
        chk("l3_t3_rdata", b_d_rdata, 32'hCAFEF00D);
        chk("l3_t3_i_gnt", b_i_gnt, 0);
        cyc();                                   // T+4
        #1;
        chk("l3_t4_i_gnt", b_i_gnt, 1);
        chk("l3_t4_rvalid", b_d_rvalid, 0);
        chk("l3_t4_addr", b_mem_addr, 32'h400);
        cyc();
        b_i_req = 1'b0;
        cyc();
        cyc();
        #1;
        chk("l3_i_rvalid", b_i_rvalid, 1);
        cyc();

        // B: reset during a latency-3 read; last owner is I so D wins here
        b_i_req = 1'b1; b_d_req = 1'b1;
        #1;
        chk("rw_d_gnt", b_d_gnt, 1);
        chk("rw_i_gnt", b_i_gnt, 0);
        cyc();                                   // T+1
        rst = 1'b1;
        #1;
        chk("rw_busy", b_busy, 0);
        chk("rw_mem_en", b_mem_en, 0);
        chk("rw_gnt", b_i_gnt | b_d_gnt, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rw_no_rvalid", b_d_rvalid | b_i_rvalid, 0);
            chk("rw_d_rdata", b_d_rdata, 0);
        end
        rst = 1'b0;
        #1;
        chk("rw_tie_i", b_i_gnt, 1);
        chk("rw_tie_d", b_d_gnt, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rw_post_d_rvalid", b_d_rvalid, 0);
        end
        b_i_req = 1'b0; b_d_req = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
